// File: rtl/rarp_rec.sv
// rarp_rec: receive-side RARP/ARP packet parser.
// Takes a 28-byte packet as seven 32-bit words, one per clock, MSB first.
// Each word is sliced straight into the header field registers it feeds.
// input_ack flags that the whole packet has been captured.
//
// Optional build macro: RARP_OP_CHECK_EN
//   When defined, input_ack is raised in DONE only if the address lengths
//   are 6/4 and the opcode is a RARP request (3) or reply (4).
//
// Handshake: there is no input valid. Every non-reset rising edge in RECV
// consumes input_rec as the next word. input_ack is a level that stays high
// from the word6 capture edge until the next rst; no ready/backpressure.
module rarp_rec (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_rec,
  output logic [15:0] hdr_type,
  output logic [15:0] proto_type,
  output logic [7:0]  hdr_addr_length,
  output logic [7:0]  pro_addr_length,
  output logic [15:0] operation,
  output logic [47:0] send_hdr_addr,
  output logic [31:0] send_ip_addr,
  output logic [47:0] target_hdr_addr,
  output logic [31:0] target_ip_addr,
  output logic        input_ack
);

  typedef enum logic {
    RECV = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] cnt;
  logic [6:0] word_cap;   // one-hot: which word this edge captures
  logic       last_word;  // this edge captures word6
  logic       ack_ok;     // packet acceptable for input_ack

`ifdef RARP_OP_CHECK_EN
  // Lengths and opcode are already registered by the time word6 arrives.
  assign ack_ok = (hdr_addr_length == 8'h06) &&
                  (pro_addr_length == 8'h04) &&
                  ((operation == 16'h0003) || (operation == 16'h0004));
`else
  assign ack_ok = 1'b1;
`endif

  // State and word counter; counter saturates at 6 and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECV;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      if (state == RECV && cnt != 3'd6) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  // Next-state and per-word capture enables.
  always_comb begin
    next_state = state;
    word_cap   = 7'b0;
    last_word  = 1'b0;
    case (state)
      RECV: begin
        word_cap = 7'b1 << cnt;
        if (cnt == 3'd6) begin
          last_word  = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = DONE;
      end
      default: begin
        next_state = RECV;
      end
    endcase
  end

  // Field registers: each updates only on the edge that captures its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_type        <= 16'h0;
      proto_type      <= 16'h0;
      hdr_addr_length <= 8'h0;
      pro_addr_length <= 8'h0;
      operation       <= 16'h0;
      send_hdr_addr   <= 48'h0;
      send_ip_addr    <= 32'h0;
      target_hdr_addr <= 48'h0;
      target_ip_addr  <= 32'h0;
    end else begin
      if (word_cap[0]) begin
        hdr_type   <= input_rec[31:16];
        proto_type <= input_rec[15:0];
      end
      if (word_cap[1]) begin
        hdr_addr_length <= input_rec[31:24];
        pro_addr_length <= input_rec[23:16];
        operation       <= input_rec[15:0];
      end
      if (word_cap[2]) begin
        send_hdr_addr[47:16] <= input_rec;
      end
      if (word_cap[3]) begin
        send_hdr_addr[15:0] <= input_rec[31:16];
        send_ip_addr[31:16] <= input_rec[15:0];
      end
      if (word_cap[4]) begin
        send_ip_addr[15:0]     <= input_rec[31:16];
        target_hdr_addr[47:32] <= input_rec[15:0];
      end
      if (word_cap[5]) begin
        target_hdr_addr[31:0] <= input_rec;
      end
      if (word_cap[6]) begin
        target_ip_addr <= input_rec;
      end
    end
  end

  // Packet-complete flag: set on the word6 edge, held until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      input_ack <= 1'b0;
    end else if (last_word) begin
      input_ack <= ack_ok;
    end
  end

endmodule

// File: tb/tb_rarp_rec.sv
// Testbench for rarp_rec: directed packets with hand-computed field values.
// Stimulus pushes expected output records into exp_q; the monitor pops and
// compares them on the following falling edge.
module tb_rarp_rec;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_rec = 32'h0;
  logic [15:0] hdr_type;
  logic [15:0] proto_type;
  logic [7:0]  hdr_addr_length;
  logic [7:0]  pro_addr_length;
  logic [15:0] operation;
  logic [47:0] send_hdr_addr;
  logic [31:0] send_ip_addr;
  logic [47:0] target_hdr_addr;
  logic [31:0] target_ip_addr;
  logic        input_ack;

  always #5 clk = ~clk;

  rarp_rec dut (
    .clk             (clk),
    .rst             (rst),
    .input_rec       (input_rec),
    .hdr_type        (hdr_type),
    .proto_type      (proto_type),
    .hdr_addr_length (hdr_addr_length),
    .pro_addr_length (pro_addr_length),
    .operation       (operation),
    .send_hdr_addr   (send_hdr_addr),
    .send_ip_addr    (send_ip_addr),
    .target_hdr_addr (target_hdr_addr),
    .target_ip_addr  (target_ip_addr),
    .input_ack       (input_ack)
  );

  typedef struct packed {
    logic [15:0] ht;
    logic [15:0] pt;
    logic [7:0]  hal;
    logic [7:0]  pal;
    logic [15:0] op;
    logic [47:0] sha;
    logic [31:0] sip;
    logic [47:0] tha;
    logic [31:0] tip;
    logic        ack;
  } rec_t;

  localparam int W = $bits(rec_t);

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable here, half a cycle after the edge.
  always @(negedge clk) begin
    rec_t e;
    while (exp_q.size() > 0) begin
      e = rec_t'(exp_q.pop_front());
      cmp("hdr_type",        64'(hdr_type),        64'(e.ht));
      cmp("proto_type",      64'(proto_type),      64'(e.pt));
      cmp("hdr_addr_length", 64'(hdr_addr_length), 64'(e.hal));
      cmp("pro_addr_length", 64'(pro_addr_length), 64'(e.pal));
      cmp("operation",       64'(operation),       64'(e.op));
      cmp("send_hdr_addr",   64'(send_hdr_addr),   64'(e.sha));
      cmp("send_ip_addr",    64'(send_ip_addr),    64'(e.sip));
      cmp("target_hdr_addr", 64'(target_hdr_addr), 64'(e.tha));
      cmp("target_ip_addr",  64'(target_ip_addr),  64'(e.tip));
      cmp("input_ack",       64'(input_ack),       64'(e.ack));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    input_rec = w;
    @(posedge clk); #1;
  endtask

  task automatic expect_rec(input rec_t r);
    exp_q.push_back(W'(r));
  endtask

  task automatic send_packet(input logic [31:0] p [7]);
    for (int i = 0; i < 7; i++) send_word(p[i]);
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] pkt1 [7] = '{32'h8559D54D, 32'h10100026, 32'hEAD4AEAD, 32'hE9DDAEA5,
                            32'hCCDEEA0D, 32'hD557BB3B, 32'hBDD95B3B};
  logic [31:0] pkt2 [7] = '{32'hAB576B4D, 32'hB52FAD4D, 32'hBEA536B5, 32'h29AD5F75,
                            32'h17F754E9, 32'h7AABB8E9, 32'h2ADAB5DD};
  logic [31:0] pkt3 [7] = '{32'h00010800, 32'h06040003, 32'hEAD4AEAD, 32'hE9DDAEA5,
                            32'hCCDEEA0D, 32'hD557BB3B, 32'hBDD95B3B};

  rec_t zero_r, p1_r, p2_r, p3_r, part_r;

  initial begin
    zero_r = '0;
    p1_r = '{ht: 16'h8559, pt: 16'hD54D, hal: 8'h10, pal: 8'h10, op: 16'h0026,
             sha: 48'hEAD4AEADE9DD, sip: 32'hAEA5CCDE, tha: 48'hEA0DD557BB3B,
             tip: 32'hBDD95B3B, ack: 1'b1};
`ifdef RARP_OP_CHECK_EN
    p1_r.ack = 1'b0;
`endif
    p2_r = '{ht: 16'hAB57, pt: 16'h6B4D, hal: 8'hB5, pal: 8'h2F, op: 16'hAD4D,
             sha: 48'hBEA536B529AD, sip: 32'h5F7517F7, tha: 48'h54E97AABB8E9,
             tip: 32'h2ADAB5DD, ack: 1'b1};
`ifdef RARP_OP_CHECK_EN
    p2_r.ack = 1'b0;
`endif
    p3_r = '{ht: 16'h0001, pt: 16'h0800, hal: 8'h06, pal: 8'h04, op: 16'h0003,
             sha: 48'hEAD4AEADE9DD, sip: 32'hAEA5CCDE, tha: 48'hEA0DD557BB3B,
             tip: 32'hBDD95B3B, ack: 1'b1};

    // 1. reset state
    apply_reset();
    expect_rec(zero_r);
    @(negedge clk); #1;

    // 2. packet 1: ack must still be low after six words, high after seven
    for (int i = 0; i < 6; i++) send_word(pkt1[i]);
    part_r = p1_r;
    part_r.tip = 32'h0;
    part_r.ack = 1'b0;
    expect_rec(part_r);
    @(negedge clk); #1;
    send_word(pkt1[6]);
    expect_rec(p1_r);
    @(negedge clk); #1;

    // 3. words after DONE are ignored
    for (int i = 0; i < 5; i++) begin
      send_word($urandom_range(32'hFFFF_FFFF, 0));
      expect_rec(p1_r);
      @(negedge clk); #1;
    end

    // 4. reset then packet 2
    apply_reset();
    expect_rec(zero_r);
    @(negedge clk); #1;
    send_packet(pkt2);
    expect_rec(p2_r);
    @(negedge clk); #1;

    // 5. reset mid-packet after three words
    apply_reset();
    for (int i = 0; i < 3; i++) send_word(pkt1[i]);
    part_r = '0;
    part_r.ht  = 16'h8559;
    part_r.pt  = 16'hD54D;
    part_r.hal = 8'h10;
    part_r.pal = 8'h10;
    part_r.op  = 16'h0026;
    part_r.sha = 48'hEAD4AEAD0000;
    expect_rec(part_r);
    @(negedge clk); #1;
    apply_reset();
    expect_rec(zero_r);
    @(negedge clk); #1;
    send_packet(pkt2);
    expect_rec(p2_r);
    @(negedge clk); #1;

    // 6. valid RARP lengths/opcode: ack in both builds
    apply_reset();
    send_packet(pkt3);
    expect_rec(p3_r);
    @(negedge clk); #1;

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
